// File: rtl/bldc_cmd_sequencer.sv
// bldc_cmd_sequencer: per-motor command scheduler for BLDC driver channels.
// Accepts duty/direction commands, slew-limits each channel on a shared prescaler tick,
// sequences reversals through ramp-to-zero plus a dead dwell, runs a command watchdog and
// recovers driver faults by pulsing the enable low a bounded number of times.
module bldc_cmd_sequencer #(
    parameter int unsigned NUM_MOTORS    = 5,
    parameter int unsigned DUTY_WIDTH    = 10,
    parameter int unsigned TICK_DIV      = 1024,
    parameter int unsigned SLEW_STEP     = 4,
    parameter int unsigned REVERSE_DWELL = 16,
    parameter int unsigned WDT_TICKS     = 2000,
    parameter int unsigned FAULT_HOLD    = 2,
    parameter int unsigned MAX_RETRIES   = 3
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             cmd_valid,
    output logic                             cmd_ready,
    input  logic [$clog2(NUM_MOTORS)-1:0]    cmd_motor,
    input  logic [DUTY_WIDTH-1:0]            cmd_duty,
    input  logic                             cmd_dir,
    output logic                             cmd_err,
    input  logic [NUM_MOTORS-1:0]            motor_fault,
    output logic [NUM_MOTORS-1:0]            motor_en,
    output logic [NUM_MOTORS*DUTY_WIDTH-1:0] motor_duty,
    output logic [NUM_MOTORS-1:0]            motor_dir,
    output logic [NUM_MOTORS-1:0]            motor_dead,
    output logic                             wdt_expired
);

    localparam int unsigned IDX_W    = $clog2(NUM_MOTORS);
    localparam int unsigned PRE_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned WDT_W    = $clog2(WDT_TICKS + 1);
    localparam int unsigned DWL_W    = (REVERSE_DWELL > 1) ? $clog2(REVERSE_DWELL) : 1;
    localparam int unsigned HOLD_W   = (FAULT_HOLD > 1) ? $clog2(FAULT_HOLD) : 1;
    localparam int unsigned RET_W    = $clog2(MAX_RETRIES + 2);
    localparam int unsigned MAX_DUTY = (1 << DUTY_WIDTH) - 1;
    localparam logic [DUTY_WIDTH-1:0] STEP =
        (SLEW_STEP > MAX_DUTY) ? {DUTY_WIDTH{1'b1}} : DUTY_WIDTH'(SLEW_STEP);

    typedef enum logic [2:0] {StIdle, StRamp, StDwell, StFaultClr, StDead} state_e;

    // Shared control state
    logic                  ready_q;
    logic                  err_q, err_d;
    logic                  wdt_exp_q, wdt_exp_d;
    logic [PRE_W-1:0]      pre_q, pre_d;
    logic [WDT_W-1:0]      wdt_q, wdt_d;
    logic [NUM_MOTORS-1:0] fault_q;
    logic                  accept, bad_idx, tick, wdt_fire;

    // Per-channel state
    state_e                state_q [NUM_MOTORS];
    state_e                state_d [NUM_MOTORS];
    logic [DUTY_WIDTH-1:0] duty_q  [NUM_MOTORS];
    logic [DUTY_WIDTH-1:0] duty_d  [NUM_MOTORS];
    logic [DUTY_WIDTH-1:0] tgt_q   [NUM_MOTORS];
    logic [DUTY_WIDTH-1:0] tgt_d   [NUM_MOTORS];
    logic [RET_W-1:0]      retry_q [NUM_MOTORS];
    logic [RET_W-1:0]      retry_d [NUM_MOTORS];
    logic [DWL_W-1:0]      dwell_q [NUM_MOTORS];
    logic [DWL_W-1:0]      dwell_d [NUM_MOTORS];
    logic [HOLD_W-1:0]     hold_q  [NUM_MOTORS];
    logic [HOLD_W-1:0]     hold_d  [NUM_MOTORS];
    logic [NUM_MOTORS-1:0] dir_q, dir_d, tdir_q, tdir_d;

    logic [DUTY_WIDTH-1:0] goal, diff;
    logic                  mismatch;

    // Handshake decode, prescaler and watchdog next-state
    always_comb begin
        accept    = cmd_valid & ready_q;
        bad_idx   = ({{(32 - IDX_W){1'b0}}, cmd_motor} >= NUM_MOTORS);
        tick      = (pre_q == PRE_W'(TICK_DIV - 1));
        pre_d     = tick ? '0 : pre_q + PRE_W'(1);
        err_d     = accept & bad_idx;
        wdt_fire  = tick & ~accept & (wdt_q == WDT_W'(WDT_TICKS - 1));
        wdt_d     = wdt_q;
        wdt_exp_d = wdt_exp_q;
        if (accept) begin
            // Any accepted command, even a dropped bad-index one, feeds the watchdog
            wdt_d     = '0;
            wdt_exp_d = 1'b0;
        end else if (tick && (wdt_q != WDT_W'(WDT_TICKS))) begin
            wdt_d = wdt_q + WDT_W'(1);
        end
        if (wdt_fire) begin
            wdt_exp_d = 1'b1;
        end
    end

    // Per-channel target update and FSM next-state
    always_comb begin
        goal     = '0;
        diff     = '0;
        mismatch = 1'b0;
        dir_d    = dir_q;
        tdir_d   = tdir_q;
        for (int i = 0; i < NUM_MOTORS; i++) begin
            state_d[i] = state_q[i];
            duty_d[i]  = duty_q[i];
            tgt_d[i]   = tgt_q[i];
            retry_d[i] = retry_q[i];
            dwell_d[i] = dwell_q[i];
            hold_d[i]  = hold_q[i];

            if (wdt_fire) begin
                tgt_d[i] = '0;
            end
            if (accept && !bad_idx && (cmd_motor == IDX_W'(i))) begin
                tgt_d[i]  = cmd_duty;
                tdir_d[i] = cmd_dir;
                if (cmd_duty == '0) begin
                    retry_d[i] = '0;
                end
            end

            mismatch = (dir_q[i] != tdir_q[i]);
            goal     = mismatch ? '0 : tgt_q[i];

            unique case (state_q[i])
                StIdle: begin
                    duty_d[i] = '0;
                    if (fault_q[i]) begin
                        state_d[i] = StFaultClr;
                        hold_d[i]  = '0;
                        retry_d[i] = retry_q[i] + RET_W'(1);
                    end else if (tgt_q[i] != '0) begin
                        state_d[i] = StRamp;
                        dir_d[i]   = tdir_q[i];
                    end
                end
                StRamp: begin
                    if (fault_q[i]) begin
                        state_d[i] = StFaultClr;
                        duty_d[i]  = '0;
                        hold_d[i]  = '0;
                        retry_d[i] = retry_q[i] + RET_W'(1);
                    end else if ((duty_q[i] == '0) && (tgt_q[i] == '0)) begin
                        state_d[i] = StIdle;
                    end else if ((duty_q[i] == '0) && mismatch) begin
                        state_d[i] = StDwell;
                        dwell_d[i] = '0;
                    end else if (tick) begin
                        // Step by at most STEP, never past the goal
                        if (goal > duty_q[i]) begin
                            diff      = goal - duty_q[i];
                            duty_d[i] = duty_q[i] + ((diff > STEP) ? STEP : diff);
                        end else begin
                            diff      = duty_q[i] - goal;
                            duty_d[i] = duty_q[i] - ((diff > STEP) ? STEP : diff);
                        end
                    end
                end
                StDwell: begin
                    duty_d[i] = '0;
                    if (tick) begin
                        if (dwell_q[i] == DWL_W'(REVERSE_DWELL - 1)) begin
                            dir_d[i]   = tdir_q[i];
                            state_d[i] = StRamp;
                        end else begin
                            dwell_d[i] = dwell_q[i] + DWL_W'(1);
                        end
                    end
                end
                StFaultClr: begin
                    duty_d[i] = '0;
                    if (hold_q[i] == HOLD_W'(FAULT_HOLD - 1)) begin
                        state_d[i] = (retry_q[i] > RET_W'(MAX_RETRIES)) ? StDead : StIdle;
                    end else begin
                        hold_d[i] = hold_q[i] + HOLD_W'(1);
                    end
                end
                StDead: begin
                    duty_d[i] = '0;
                end
                default: begin
                    state_d[i] = StIdle;
                    duty_d[i]  = '0;
                end
            endcase
        end
    end

    // Shared state registers; the fault inputs are synchronised here
    always_ff @(posedge clk) begin
        if (rst) begin
            ready_q   <= 1'b0;
            err_q     <= 1'b0;
            wdt_exp_q <= 1'b0;
            pre_q     <= '0;
            wdt_q     <= '0;
            fault_q   <= '0;
        end else begin
            ready_q   <= 1'b1;
            err_q     <= err_d;
            wdt_exp_q <= wdt_exp_d;
            pre_q     <= pre_d;
            wdt_q     <= wdt_d;
            fault_q   <= motor_fault;
        end
    end

    // Per-channel state registers
    always_ff @(posedge clk) begin
        if (rst) begin
            dir_q  <= '0;
            tdir_q <= '0;
            for (int i = 0; i < NUM_MOTORS; i++) begin
                state_q[i] <= StIdle;
                duty_q[i]  <= '0;
                tgt_q[i]   <= '0;
                retry_q[i] <= '0;
                dwell_q[i] <= '0;
                hold_q[i]  <= '0;
            end
        end else begin
            dir_q  <= dir_d;
            tdir_q <= tdir_d;
            for (int i = 0; i < NUM_MOTORS; i++) begin
                state_q[i] <= state_d[i];
                duty_q[i]  <= duty_d[i];
                tgt_q[i]   <= tgt_d[i];
                retry_q[i] <= retry_d[i];
                dwell_q[i] <= dwell_d[i];
                hold_q[i]  <= hold_d[i];
            end
        end
    end

    // Output decode; enables stay low until the first clock out of reset
    always_comb begin
        cmd_ready   = ready_q;
        cmd_err     = err_q;
        wdt_expired = wdt_exp_q;
        motor_dir   = dir_q;
        motor_en    = '0;
        motor_dead  = '0;
        motor_duty  = '0;
        for (int i = 0; i < NUM_MOTORS; i++) begin
            motor_en[i]   = ready_q & ((state_q[i] == StIdle) || (state_q[i] == StRamp));
            motor_dead[i] = (state_q[i] == StDead);
            motor_duty[i*DUTY_WIDTH +: DUTY_WIDTH] = duty_q[i];
        end
    end

endmodule

// File: tb/tb_bldc_cmd_sequencer.sv
// tb_bldc_cmd_sequencer: directed bench with small timing parameters (tick every 4 clocks).
module tb_bldc_cmd_sequencer;

    localparam int NM = 5;
    localparam int DW = 10;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cmd_valid = 1'b0;
    logic [2:0]    cmd_motor = '0;
    logic [DW-1:0] cmd_duty = '0;
    logic          cmd_dir = 1'b0;
    logic [NM-1:0] motor_fault = '0;
    logic          cmd_ready, cmd_err, wdt_expired;
    logic [NM-1:0] motor_en, motor_dir, motor_dead;
    logic [NM*DW-1:0] motor_duty;

    int n_checks = 0;
    int n_errors = 0;

    // Tick locator: the prescaler restarts at 0 out of reset, so every 4th clock is a tick
    logic [1:0] pc = '0;
    logic       tick_edge = 1'b0;

    int          t1_duty [4] = '{4, 8, 10, 10};
    int          t4_duty [8] = '{4, 8, 12, 12, 12, 8, 4, 0};
    logic [7:0]  t4_wdt      = 8'b1111_0000;
    logic [12:0] en_pat      = 13'b0001001001001;
    logic [12:0] dead_pat    = 13'b1000000000000;

    bldc_cmd_sequencer #(
        .NUM_MOTORS   (NM),
        .DUTY_WIDTH   (DW),
        .TICK_DIV     (4),
        .SLEW_STEP    (4),
        .REVERSE_DWELL(2),
        .WDT_TICKS    (5),
        .FAULT_HOLD   (2),
        .MAX_RETRIES  (3)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_motor  (cmd_motor),
        .cmd_duty   (cmd_duty),
        .cmd_dir    (cmd_dir),
        .cmd_err    (cmd_err),
        .motor_fault(motor_fault),
        .motor_en   (motor_en),
        .motor_duty (motor_duty),
        .motor_dir  (motor_dir),
        .motor_dead (motor_dead),
        .wdt_expired(wdt_expired)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        tick_edge <= !rst && (pc == 2'd3);
        pc        <= rst ? 2'd0 : pc + 2'd1;
    end

    function automatic logic [DW-1:0] duty_of(input int ch);
        return motor_duty[ch*DW +: DW];
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_tick();
        int n;
        n = 0;
        do begin
            cyc(1);
            n++;
        end while (!tick_edge && n < 8);
    endtask

    task automatic send(input logic [2:0] m, input logic [DW-1:0] d, input logic dir);
        cmd_motor = m;
        cmd_duty  = d;
        cmd_dir   = dir;
        cmd_valid = 1'b1;
        cyc(1);
        cmd_valid = 1'b0;
    endtask

    task automatic all_zero(input string tag);
        chk({tag, "_ready"}, cmd_ready, 0);
        chk({tag, "_err"}, cmd_err, 0);
        chk({tag, "_en"}, motor_en, 0);
        chk({tag, "_duty"}, motor_duty, 0);
        chk({tag, "_dir"}, motor_dir, 0);
        chk({tag, "_dead"}, motor_dead, 0);
        chk({tag, "_wdt"}, wdt_expired, 0);
    endtask

    // Leaves the bench 1 time unit after the first clock out of reset
    task automatic do_reset(input string tag);
        rst         = 1'b1;
        cmd_valid   = 1'b0;
        motor_fault = '0;
        cyc(2);
        all_zero(tag);
        rst = 1'b0;
        cyc(1);
        chk({tag, "_ready_up"}, cmd_ready, 1);
        chk({tag, "_en_up"}, motor_en, 5'h1f);
    endtask

    task automatic fault_pulse(input int ch);
        motor_fault[ch] = 1'b1;
        cyc(1);
        motor_fault[ch] = 1'b0;
        cyc(5);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: observed no end of sequence, expected finish before 100000 ns");
        $fatal(1);
    end

    initial begin
        // Basic ramp: 4, 8, 10, then hold without overshoot
        do_reset("rst1");
        send(3'd0, 10'd10, 1'b0);
        for (int i = 0; i < 4; i++) begin
            wait_tick();
            chk($sformatf("t1_duty[%0d]", i), duty_of(0), t1_duty[i]);
            chk($sformatf("t1_en[%0d]", i), motor_en[0], 1);
        end

        // Reversal through ramp-down and a 2-tick dwell
        do_reset("rst2");
        send(3'd1, 10'd8, 1'b0);
        wait_tick();
        wait_tick();
        chk("t2_pre", duty_of(1), 8);
        send(3'd1, 10'd8, 1'b1);
        wait_tick();
        chk("t2_down1", duty_of(1), 4);
        chk("t2_dir_old", motor_dir[1], 0);
        wait_tick();
        chk("t2_down0", duty_of(1), 0);
        cyc(1);
        chk("t2_dwell_en", motor_en[1], 0);
        wait_tick();
        chk("t2_dwell_en2", motor_en[1], 0);
        chk("t2_dwell_dir", motor_dir[1], 0);
        send(3'd1, 10'd8, 1'b1);
        wait_tick();
        chk("t2_flip_en", motor_en[1], 1);
        chk("t2_flip_dir", motor_dir[1], 1);
        chk("t2_flip_duty", duty_of(1), 0);
        wait_tick();
        chk("t2_up4", duty_of(1), 4);
        wait_tick();
        chk("t2_up8", duty_of(1), 8);
        chk("t2_m0", duty_of(0), 0);

        // Fault held high: three recoveries, then latched dead
        do_reset("rst3");
        motor_fault = 5'b00100;
        for (int i = 0; i < 13; i++) begin
            cyc(1);
            chk($sformatf("t3_en[%0d]", i), motor_en[2], en_pat[i]);
            chk($sformatf("t3_dead[%0d]", i), motor_dead[2], dead_pat[i]);
        end
        chk("t3_others", motor_en & 5'b11011, 5'b11011);
        motor_fault = '0;
        cyc(10);
        chk("t3_dead_hold", motor_dead[2], 1);
        send(3'd2, 10'd8, 1'b0);
        wait_tick();
        wait_tick();
        chk("t3_dead_duty", duty_of(2), 0);
        chk("t3_dead_en", motor_en[2], 0);
        chk("t3_dead_still", motor_dead[2], 1);

        // A duty-0 command clears the retry count
        do_reset("rst3b");
        fault_pulse(4);
        fault_pulse(4);
        fault_pulse(4);
        chk("t3b_alive3", motor_dead[4], 0);
        send(3'd4, 10'd0, 1'b0);
        fault_pulse(4);
        fault_pulse(4);
        chk("t3b_alive5", motor_dead[4], 0);
        chk("t3b_en", motor_en[4], 1);

        // Watchdog fires at the 5th tick after the last accept, then ramps down
        do_reset("rst4");
        send(3'd3, 10'd12, 1'b0);
        for (int i = 0; i < 8; i++) begin
            wait_tick();
            chk($sformatf("t4_duty[%0d]", i), duty_of(3), t4_duty[i]);
            chk($sformatf("t4_wdt[%0d]", i), wdt_expired, t4_wdt[i]);
        end
        send(3'd3, 10'd0, 1'b0);
        chk("t4_wdt_clr", wdt_expired, 0);
        chk("t4_en", motor_en[3], 1);

        // Bad index: one-cycle error pulse, no channel touched
        do_reset("rst5");
        send(3'd7, 10'd100, 1'b1);
        chk("t5_err_hi", cmd_err, 1);
        cyc(1);
        chk("t5_err_lo", cmd_err, 0);
        wait_tick();
        wait_tick();
        chk("t5_duty", motor_duty, 0);
        chk("t5_dir", motor_dir, 0);
        chk("t5_en", motor_en, 5'h1f);

        // Command accepted on a tick edge: that tick still steps toward the old target
        do_reset("rst5b");
        send(3'd0, 10'd8, 1'b0);
        wait_tick();
        wait_tick();
        chk("t5b_pre", duty_of(0), 8);
        cyc(3);
        send(3'd0, 10'd20, 1'b0);
        chk("t5b_coll", duty_of(0), 8);
        wait_tick();
        chk("t5b_next", duty_of(0), 12);
        wait_tick();
        chk("t5b_next2", duty_of(0), 16);

        // Reset while one channel dwells and another ramps
        do_reset("rst6");
        send(3'd1, 10'd4, 1'b0);
        wait_tick();
        chk("t6_m1_up", duty_of(1), 4);
        send(3'd1, 10'd4, 1'b1);
        send(3'd0, 10'd40, 1'b1);
        wait_tick();
        chk("t6_m1_zero", duty_of(1), 0);
        chk("t6_m0_ramp", duty_of(0), 4);
        chk("t6_m0_dir", motor_dir[0], 1);
        cyc(1);
        chk("t6_m1_dwell", motor_en[1], 0);
        chk("t6_m0_en", motor_en[0], 1);
        rst = 1'b1;
        cyc(1);
        all_zero("t6_mid");
        rst = 1'b0;
        chk("t6_ready_low", cmd_ready, 0);
        cyc(1);
        chk("t6_ready", cmd_ready, 1);
        chk("t6_en", motor_en, 5'h1f);
        chk("t6_duty", motor_duty, 0);
        chk("t6_dir", motor_dir, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
